ctrl_pipe_sequencer: RTL and testbench

CTRL_PIPE_SEQUENCER -- requirements
Module: ctrl_pipe_sequencer

---
 rtl/ctrl_pipe_sequencer.sv | 88 ++++++++
 tb/tb_ctrl_pipe_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_sequencer.sv
// ctrl_pipe_sequencer: ID->EX->WB control pipeline with hazard resolution, forwarding select and event counters.
// Ports: clk/rst (sync, active-high); id_* decode-stage instruction; mem_busy freezes, br_taken squashes;
// ex_*/wb_* registered stage contents; stall_id/flush_id IF/ID control; fwd_a/fwd_b operand selects;
// stall_cnt/flush_cnt saturating bubble/flush event counters.
module ctrl_pipe_sequencer #(
  parameter int CTRL_W      = 16,
  parameter int REGEN_BIT   = 0,
  parameter int LOAD_BIT    = 1,
  parameter int STORE_BIT   = 2,
  parameter int USE_RS1_BIT = 3,
  parameter int USE_RS2_BIT = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              mem_busy,
  input  logic              br_taken,
  output logic              ex_valid,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [4:0]        ex_rd,
  output logic [4:0]        wb_rd,
  output logic              stall_id,
  output logic              flush_id,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  localparam logic [CTRL_W-1:0] WE_MASK = CTRL_W'((1 << REGEN_BIT) | (1 << STORE_BIT));
  logic              r_ex_valid, r_wb_valid;
  logic [CTRL_W-1:0] r_ex_ctrl, r_wb_ctrl;
  logic [4:0]        r_ex_rd, r_wb_rd;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
  logic              w_luh, w_freeze, w_flush, w_bubble, w_take;
  logic              w_ex_fwd, w_wb_fwd;
  assign w_luh = id_valid && r_ex_valid && r_ex_ctrl[LOAD_BIT] && r_ex_rd != 5'd0 &&
                 ((id_ctrl[USE_RS1_BIT] && id_rs1 == r_ex_rd) || (id_ctrl[USE_RS2_BIT] && id_rs2 == r_ex_rd));
  assign w_freeze = mem_busy;
  assign w_flush  = !mem_busy && br_taken;
  assign w_bubble = !mem_busy && !br_taken && w_luh;
  assign w_take   = id_valid && !w_flush && !w_bubble;
  assign stall_id = !rst && (w_freeze || w_bubble);
  assign flush_id = !rst && w_flush;
  // a load result is not available in EX, so only non-load producers forward from EX
  assign w_ex_fwd = r_ex_valid && r_ex_ctrl[REGEN_BIT] && !r_ex_ctrl[LOAD_BIT] && r_ex_rd != 5'd0;
  assign w_wb_fwd = r_wb_valid && r_wb_ctrl[REGEN_BIT] && r_wb_rd != 5'd0;
  assign fwd_a = !id_valid ? 2'b00 : (w_ex_fwd && r_ex_rd == id_rs1) ? 2'b01 :
                 (w_wb_fwd && r_wb_rd == id_rs1) ? 2'b10 : 2'b00;
  assign fwd_b = !id_valid ? 2'b00 : (w_ex_fwd && r_ex_rd == id_rs2) ? 2'b01 :
                 (w_wb_fwd && r_wb_rd == id_rs2) ? 2'b10 : 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid  <= 1'b0;
      r_ex_ctrl   <= '0;
      r_ex_rd     <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_ctrl   <= '0;
      r_wb_rd     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!w_freeze) begin
      r_wb_valid  <= r_ex_valid;
      // write enables never leave an empty EX slot
      r_wb_ctrl   <= r_ex_ctrl & (r_ex_valid ? {CTRL_W{1'b1}} : ~WE_MASK);
      r_wb_rd     <= r_ex_rd;
      r_ex_valid  <= w_take;
      r_ex_ctrl   <= w_take ? id_ctrl : '0;
      r_ex_rd     <= w_take ? id_rd : '0;
      r_stall_cnt <= r_stall_cnt + CNT_W'(w_bubble && r_stall_cnt != {CNT_W{1'b1}});
      r_flush_cnt <= r_flush_cnt + CNT_W'(w_flush && r_flush_cnt != {CNT_W{1'b1}});
    end
  end
  assign ex_valid  = r_ex_valid;
  assign ex_ctrl   = r_ex_ctrl;
  assign ex_rd     = r_ex_rd;
  assign wb_valid  = r_wb_valid;
  assign wb_ctrl   = r_wb_ctrl;
  assign wb_rd     = r_wb_rd;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_ctrl_pipe_sequencer.sv
// tb_ctrl_pipe_sequencer: directed self-checking bench for ctrl_pipe_sequencer (default and 2-bit counter instances).
module tb_ctrl_pipe_sequencer;
  localparam logic [15:0] ALU = 16'h0019;
  localparam logic [15:0] LW  = 16'h000B;
  localparam logic [15:0] BR  = 16'h0018;
  logic        clk = 1'b0;
  logic        rst, id_valid, mem_busy, br_taken;
  logic [15:0] id_ctrl;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_valid, wb_valid, stall_id, flush_id;
  logic [15:0] ex_ctrl, wb_ctrl, stall_cnt, flush_cnt;
  logic [4:0]  ex_rd, wb_rd;
  logic [1:0]  fwd_a, fwd_b;
  logic        s_ex_valid, s_wb_valid, s_stall_id, s_flush_id;
  logic [15:0] s_ex_ctrl, s_wb_ctrl;
  logic [4:0]  s_ex_rd, s_wb_rd;
  logic [1:0]  s_fwd_a, s_fwd_b, s_stall_cnt, s_flush_cnt;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  ctrl_pipe_sequencer u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .mem_busy(mem_busy), .br_taken(br_taken), .ex_valid(ex_valid), .wb_valid(wb_valid),
    .ex_ctrl(ex_ctrl), .wb_ctrl(wb_ctrl), .ex_rd(ex_rd), .wb_rd(wb_rd), .stall_id(stall_id),
    .flush_id(flush_id), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  ctrl_pipe_sequencer #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .mem_busy(mem_busy), .br_taken(br_taken), .ex_valid(s_ex_valid), .wb_valid(s_wb_valid),
    .ex_ctrl(s_ex_ctrl), .wb_ctrl(s_wb_ctrl), .ex_rd(s_ex_rd), .wb_rd(s_wb_rd), .stall_id(s_stall_id),
    .flush_id(s_flush_id), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic id(input logic v, input logic [15:0] c, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
    id_valid = v;
    id_ctrl  = c;
    id_rs1   = r1;
    id_rs2   = r2;
    id_rd    = d;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    mem_busy = 1'b1;
    br_taken = 1'b1;
    id(1'b1, ALU, 5'd1, 5'd2, 5'd3);
    chk("rst_stall_id", stall_id, 0);
    chk("rst_flush_id", flush_id, 0);
    tick;
    tick;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    rst = 1'b0;
    mem_busy = 1'b0;
    br_taken = 1'b0;
    id(1'b1, ALU, 5'd1, 5'd2, 5'd5);
    chk("add_stall", stall_id, 0);
    tick;
    chk("add_ex_valid", ex_valid, 1);
    chk("add_ex_ctrl", ex_ctrl, ALU);
    chk("add_ex_rd", ex_rd, 5);
    id(1'b1, ALU, 5'd5, 5'd3, 5'd6);
    chk("sub_fwd_a_ex", fwd_a, 2'b01);
    chk("sub_fwd_b", fwd_b, 2'b00);
    chk("sub_stall", stall_id, 0);
    tick;
    id(1'b1, ALU, 5'd1, 5'd2, 5'd8);
    chk("xor_fwd_a", fwd_a, 2'b00);
    chk("xor_fwd_b", fwd_b, 2'b00);
    tick;
    chk("sub_wb_rd", wb_rd, 6);
    id(1'b1, ALU, 5'd6, 5'd8, 5'd9);
    chk("gap_fwd_a_wb", fwd_a, 2'b10);
    chk("gap_fwd_b_ex", fwd_b, 2'b01);
    chk("gap_stall", stall_id, 0);
    id(1'b0, ALU, 5'd6, 5'd8, 5'd9);
    chk("novalid_fwd_a", fwd_a, 2'b00);
    chk("novalid_fwd_b", fwd_b, 2'b00);
    id(1'b1, ALU, 5'd6, 5'd8, 5'd9);
    tick;
    id(1'b1, LW, 5'd1, 5'd0, 5'd7);
    tick;
    id(1'b1, ALU, 5'd2, 5'd7, 5'd10);
    chk("luh_stall", stall_id, 1);
    chk("luh_flush", flush_id, 0);
    chk("luh_fwd_b", fwd_b, 2'b00);
    tick;
    chk("bub_ex_valid", ex_valid, 0);
    chk("bub_ex_ctrl", ex_ctrl, 0);
    chk("bub_wb_rd", wb_rd, 7);
    chk("bub_stall_cnt", stall_cnt, 1);
    chk("bub_stall_once", stall_id, 0);
    chk("bub_fwd_b_wb", fwd_b, 2'b10);
    chk("bub_fwd_a", fwd_a, 2'b00);
    tick;
    chk("luh_adv_ex_rd", ex_rd, 10);
    chk("luh_adv_stall_cnt", stall_cnt, 1);
    id(1'b1, BR, 5'd1, 5'd2, 5'd0);
    tick;
    chk("br_ex_ctrl", ex_ctrl, BR);
    id(1'b1, ALU, 5'd3, 5'd4, 5'd11);
    br_taken = 1'b1;
    #1;
    chk("br_flush_id", flush_id, 1);
    chk("br_stall_id", stall_id, 0);
    tick;
    br_taken = 1'b0;
    chk("br_ex_valid", ex_valid, 0);
    chk("br_ex_rd", ex_rd, 0);
    chk("br_wb_ctrl", wb_ctrl, BR);
    chk("br_flush_cnt", flush_cnt, 1);
    id(1'b1, ALU, 5'd1, 5'd2, 5'd13);
    tick;
    id(1'b1, LW, 5'd1, 5'd0, 5'd12);
    tick;
    id(1'b1, ALU, 5'd12, 5'd2, 5'd14);
    br_taken = 1'b1;
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_stall_id", stall_id, 1);
      chk("frz_flush_id", flush_id, 0);
      tick;
      chk("frz_ex_rd", ex_rd, 12);
      chk("frz_wb_rd", wb_rd, 13);
      chk("frz_stall_cnt", stall_cnt, 1);
      chk("frz_flush_cnt", flush_cnt, 1);
    end
    mem_busy = 1'b0;
    #1;
    chk("unfrz_flush_id", flush_id, 1);
    chk("unfrz_stall_id", stall_id, 0);
    tick;
    br_taken = 1'b0;
    chk("unfrz_ex_valid", ex_valid, 0);
    chk("unfrz_wb_rd", wb_rd, 12);
    chk("unfrz_flush_cnt", flush_cnt, 2);
    chk("unfrz_stall_cnt", stall_cnt, 1);
    id(1'b1, LW, 5'd1, 5'd0, 5'd0);
    tick;
    id(1'b1, ALU, 5'd0, 5'd0, 5'd15);
    chk("x0_stall", stall_id, 0);
    chk("x0_fwd_a", fwd_a, 2'b00);
    chk("x0_fwd_b", fwd_b, 2'b00);
    tick;
    id(1'b1, LW, 5'd1, 5'd0, 5'd7);
    tick;
    id(1'b1, ALU, 5'd7, 5'd2, 5'd16);
    chk("rbub_stall", stall_id, 1);
    rst = 1'b1;
    #1;
    chk("rbub_rst_stall", stall_id, 0);
    tick;
    rst = 1'b0;
    chk("rbub_ex_valid", ex_valid, 0);
    chk("rbub_wb_valid", wb_valid, 0);
    chk("rbub_ex_ctrl", ex_ctrl, 0);
    chk("rbub_wb_ctrl", wb_ctrl, 0);
    chk("rbub_ex_rd", ex_rd, 0);
    chk("rbub_stall_cnt", stall_cnt, 0);
    chk("rbub_flush_cnt", flush_cnt, 0);
    id(1'b1, ALU, 5'd1, 5'd2, 5'd3);
    chk("rbub_adv_stall", stall_id, 0);
    tick;
    chk("rbub_adv_ex_valid", ex_valid, 1);
    chk("rbub_adv_ex_rd", ex_rd, 3);
    for (int i = 0; i < 5; i++) begin
      id(1'b1, LW, 5'd1, 5'd0, 5'd7);
      tick;
      id(1'b1, ALU, 5'd2, 5'd7, 5'd4);
      tick;
    end
    chk("sat_main_stall_cnt", stall_cnt, 5);
    chk("sat_small_stall_cnt", s_stall_cnt, 3);
    id(1'b0, 16'h0, 5'd0, 5'd0, 5'd0);
    br_taken = 1'b1;
    repeat (65534) tick;
    chk("sat_flush_near", flush_cnt, 16'hFFFE);
    tick;
    tick;
    chk("sat_flush_cnt", flush_cnt, 16'hFFFF);
    chk("sat_small_flush_cnt", s_flush_cnt, 3);
    chk("sat_stall_hold", stall_cnt, 5);
    br_taken = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
